// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state and grant types.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP_C        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE_C     = 4'b0011;
  localparam logic [3:0] CMD_READ_C       = 4'b0101;
  localparam logic [3:0] CMD_WRITE_C      = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE_C  = 4'b0010;
  localparam logic [3:0] CMD_AREF_C       = 4'b0001;
  localparam logic [3:0] CMD_BURST_STOP_C = 4'b0110;

  // Encoding of the last-served flag used by the write/read tie-break.
  localparam logic LAST_RD = 1'b0;
  localparam logic LAST_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_AREF = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } grant_e;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: refresh first, then write/read with a
// last-served tie-break (write wins whenever read was served last).
module sdram_arb_pick
  import sdram_pkg::*;
(
  input  logic   aref_req,
  input  logic   wr_req,
  input  logic   rd_req,
  input  logic   last_served,
  output grant_e grant
);

  // Priority pick among the pending requests.
  always_comb begin
    grant = GNT_NONE;
    if (aref_req) begin
      grant = GNT_AREF;
    end else if (wr_req && (!rd_req || (last_served == LAST_RD))) begin
      grant = GNT_WR;
    end else if (rd_req) begin
      grant = GNT_RD;
    end else begin
      grant = GNT_NONE;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter between init, refresh, write and read engines.
// Define SDRAM_ARB_RR_EN to alternate write/read grants when both are pending.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter logic [3:0]  CMD_NOP   = 4'b0111,
  parameter logic [1:0]  IDLE_BA   = 2'b11,
  parameter logic [11:0] IDLE_ADDR = 12'hFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic        busy
);

  arb_state_e state_r;
  grant_e     grant_s;
  logic       last_sel_s;
  logic       aref_en_r;
  logic       wr_en_r;
  logic       rd_en_r;
  logic       busy_r;

  sdram_arb_pick u_pick (
    .aref_req   (aref_req),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .last_served(last_sel_s),
    .grant      (grant_s)
  );

`ifdef SDRAM_ARB_RR_EN
  logic last_served_r;

  // Remember whether write or read was granted last; reset favours write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_served_r <= LAST_RD;
    end else if ((state_r == ST_ARB) && init_done) begin
      case (grant_s)
        GNT_WR:  last_served_r <= LAST_WR;
        GNT_RD:  last_served_r <= LAST_RD;
        default: last_served_r <= last_served_r;
      endcase
    end
  end

  assign last_sel_s = last_served_r;
`else
  assign last_sel_s = LAST_RD;
`endif

  // Arbitration FSM; grant pulses and busy are registered with the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      aref_en_r <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      aref_en_r <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (init_done) state_r <= ST_ARB;
        end
        ST_ARB: begin
          if (!init_done) begin
            state_r <= ST_IDLE;
          end else begin
            case (grant_s)
              GNT_AREF: begin state_r <= ST_AREF;  aref_en_r <= 1'b1; busy_r <= 1'b1; end
              GNT_WR:   begin state_r <= ST_WRITE; wr_en_r   <= 1'b1; busy_r <= 1'b1; end
              GNT_RD:   begin state_r <= ST_READ;  rd_en_r   <= 1'b1; busy_r <= 1'b1; end
              default:  state_r <= ST_ARB;
            endcase
          end
        end
        ST_AREF: begin
          if (aref_end) begin state_r <= ST_ARB; busy_r <= 1'b0; end
        end
        ST_WRITE: begin
          if (wr_end) begin state_r <= ST_ARB; busy_r <= 1'b0; end
        end
        ST_READ: begin
          if (rd_end) begin state_r <= ST_ARB; busy_r <= 1'b0; end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Owner's bus passes straight through so commands see no added latency.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_ba   = IDLE_BA;
    sdram_addr = IDLE_ADDR;
    case (state_r)
      ST_IDLE:  begin sdram_cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
      ST_AREF:  begin sdram_cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
      ST_WRITE: begin sdram_cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
      ST_READ:  begin sdram_cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
      default:  begin sdram_cmd = CMD_NOP;  sdram_ba = IDLE_BA; sdram_addr = IDLE_ADDR; end
    endcase
  end

  assign aref_en = aref_en_r;
  assign wr_en   = wr_en_r;
  assign rd_en   = rd_en_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: grant order scoreboard plus
// per-scenario bus/state checks.
module tb_sdram_arbiter;

  localparam logic [17:0] NOP_BUS  = {4'b0111, 2'b11, 12'hFFF};
  localparam logic [17:0] INIT_BUS = {4'b0010, 2'b00, 12'h000};
  localparam logic [17:0] AREF_BUS = {4'b0001, 2'b01, 12'h400};
  localparam logic [17:0] WR_BUS   = {4'b0100, 2'b10, 12'h123};
  localparam logic [17:0] RD_BUS   = {4'b0101, 2'b00, 12'h456};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_done;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic        aref_en, wr_en, rd_en, busy;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic [17:0] bus;

  int  n_tests = 0;
  int  n_fail  = 0;
  byte exp_q[$];

  assign {init_cmd, init_ba, init_addr} = INIT_BUS;
  assign {aref_cmd, aref_ba, aref_addr} = AREF_BUS;
  assign {wr_cmd, wr_ba, wr_addr}       = WR_BUS;
  assign {rd_cmd, rd_ba, rd_addr}       = RD_BUS;
  assign bus = {sdram_cmd, sdram_ba, sdram_addr};

  always #5 sys_clk = ~sys_clk;

  sdram_arbiter dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .busy(busy)
  );

  // Scoreboard: every grant pulse pops the next expected winner.
  always @(negedge sys_clk) begin
    byte got, want;
    logic [17:0] want_bus;
    if (sys_rst_n === 1'b1 && (aref_en | wr_en | rd_en) === 1'b1) begin
      got      = aref_en ? "A" : (wr_en ? "W" : "R");
      want_bus = aref_en ? AREF_BUS : (wr_en ? WR_BUS : RD_BUS);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got grant %c, none expected", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want || $countones({aref_en, wr_en, rd_en}) != 1 || bus !== want_bus) begin
          n_fail++;
          $display("FAIL sb_grant: got %c en=%b bus=%h, want %c bus=%h",
                   got, {aref_en, wr_en, rd_en}, bus, want, want_bus);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; init_done = 1'b0;
    {aref_req, aref_end, wr_req, wr_end, rd_req, rd_end} = 6'b0;
    repeat (3) cyc();
    n_tests++;
    if ({bus, aref_en, wr_en, rd_en, busy} !== {INIT_BUS, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: got bus=%h en/busy=%b, want bus=%h 0000",
               bus, {aref_en, wr_en, rd_en, busy}, INIT_BUS);
    end
    sys_rst_n = 1'b1;
    cyc(); cyc();
    n_tests++;
    if (bus !== INIT_BUS) begin
      n_fail++;
      $display("FAIL idle_wait: got bus=%h, want %h", bus, INIT_BUS);
    end
    init_done = 1'b1; wr_req = 1'b1;
    exp_q.push_back("W");
    cyc();
    n_tests++;
    if ({bus, wr_en, busy} !== {NOP_BUS, 2'b00}) begin
      n_fail++;
      $display("FAIL arb_entry: got bus=%h wr_en/busy=%b, want %h 00", bus, {wr_en, busy}, NOP_BUS);
    end
    cyc();
    wr_req = 1'b0;
    n_tests++;
    if ({bus, wr_en, busy} !== {WR_BUS, 2'b11}) begin
      n_fail++;
      $display("FAIL first_grant: got bus=%h wr_en/busy=%b, want %h 11", bus, {wr_en, busy}, WR_BUS);
    end
    wr_end = 1'b1;
    cyc();
    wr_end = 1'b0;
  endtask

  task automatic test_write_then_read();
    wr_req = 1'b1; rd_req = 1'b1;
    exp_q.push_back("W"); exp_q.push_back("R");
    cyc();
    wr_req = 1'b0;
    n_tests++;
    if ({bus, wr_en, rd_en, busy} !== {WR_BUS, 3'b101}) begin
      n_fail++;
      $display("FAIL wr_grant: got bus=%h wr/rd/busy=%b, want %h 101", bus, {wr_en, rd_en, busy}, WR_BUS);
    end
    cyc();
    n_tests++;
    if ({bus, wr_en} !== {WR_BUS, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_pulse_width: got bus=%h wr_en=%b, want %h 0", bus, wr_en, WR_BUS);
    end
    wr_end = 1'b1;
    cyc();
    wr_end = 1'b0;
    n_tests++;
    if ({bus, rd_en, busy} !== {NOP_BUS, 2'b00}) begin
      n_fail++;
      $display("FAIL nop_gap: got bus=%h rd_en/busy=%b, want %h 00", bus, {rd_en, busy}, NOP_BUS);
    end
    cyc();
    rd_req = 1'b0;
    n_tests++;
    if ({bus, rd_en} !== {RD_BUS, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_grant: got bus=%h rd_en=%b, want %h 1", bus, rd_en, RD_BUS);
    end
    rd_end = 1'b1;
    cyc();
    rd_end = 1'b0;
  endtask

  task automatic test_no_preempt();
    wr_req = 1'b1;
    exp_q.push_back("W"); exp_q.push_back("A"); exp_q.push_back("R");
    cyc();
    wr_req = 1'b0; aref_req = 1'b1; rd_req = 1'b1; rd_end = 1'b1; aref_end = 1'b1;
    cyc();
    rd_end = 1'b0; aref_end = 1'b0;
    cyc();
    n_tests++;
    if ({bus, aref_en, busy} !== {WR_BUS, 2'b01}) begin
      n_fail++;
      $display("FAIL no_preempt: got bus=%h aref_en/busy=%b, want %h 01", bus, {aref_en, busy}, WR_BUS);
    end
    wr_end = 1'b1;
    cyc();
    wr_end = 1'b0;
    cyc();
    aref_req = 1'b0;
    n_tests++;
    if ({bus, aref_en, rd_en} !== {AREF_BUS, 2'b10}) begin
      n_fail++;
      $display("FAIL aref_first: got bus=%h aref/rd=%b, want %h 10", bus, {aref_en, rd_en}, AREF_BUS);
    end
    aref_end = 1'b1;
    cyc();
    aref_end = 1'b0;
    cyc();
    rd_req = 1'b0;
    n_tests++;
    if ({bus, rd_en} !== {RD_BUS, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_after_aref: got bus=%h rd_en=%b, want %h 1", bus, rd_en, RD_BUS);
    end
    rd_end = 1'b1;
    cyc();
    rd_end = 1'b0;
  endtask

  task automatic test_init_drop();
    init_done = 1'b0;
    cyc();
    n_tests++;
    if (bus !== INIT_BUS) begin
      n_fail++;
      $display("FAIL arb_to_idle: got bus=%h, want %h", bus, INIT_BUS);
    end
    init_done = 1'b1;
    cyc();
    wr_req = 1'b1;
    exp_q.push_back("W");
    cyc();
    wr_req = 1'b0; init_done = 1'b0;
    cyc();
    n_tests++;
    if ({bus, busy} !== {WR_BUS, 1'b1}) begin
      n_fail++;
      $display("FAIL owner_ignores_init: got bus=%h busy=%b, want %h 1", bus, busy, WR_BUS);
    end
    wr_end = 1'b1;
    cyc();
    wr_end = 1'b0;
    n_tests++;
    if (bus !== NOP_BUS) begin
      n_fail++;
      $display("FAIL end_then_arb: got bus=%h, want %h", bus, NOP_BUS);
    end
    cyc();
    n_tests++;
    if (bus !== INIT_BUS) begin
      n_fail++;
      $display("FAIL late_idle: got bus=%h, want %h", bus, INIT_BUS);
    end
    init_done = 1'b1;
    cyc();
  endtask

  task automatic test_round_robin();
    byte exp_order[4];
    byte got;
    int  n;
`ifdef SDRAM_ARB_RR_EN
    exp_order = '{"W", "R", "W", "R"};
`else
    exp_order = '{"W", "W", "W", "W"};
`endif
    sys_rst_n = 1'b0;
    cyc();
    sys_rst_n = 1'b1;
    cyc();
    for (int g = 0; g < 4; g++) exp_q.push_back(exp_order[g]);
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(wr_en || rd_en) && n < 10) begin
        cyc();
        n++;
      end
      got = wr_en ? "W" : (rd_en ? "R" : "-");
      n_tests++;
      if (got !== exp_order[g]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %c, want %c", g, got, exp_order[g]);
      end
      if (got == "-") break;
      if (g == 3) begin wr_req = 1'b0; rd_req = 1'b0; end
      if (got == "W") wr_end = 1'b1; else rd_end = 1'b1;
      cyc();
      wr_end = 1'b0; rd_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1;
    exp_q.push_back("R");
    cyc();
    rd_req = 1'b0;
    n_tests++;
    if ({bus, rd_en} !== {RD_BUS, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_before_reset: got bus=%h rd_en=%b, want %h 1", bus, rd_en, RD_BUS);
    end
    cyc();
    #2 sys_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus, busy, rd_en} !== {INIT_BUS, 2'b00}) begin
      n_fail++;
      $display("FAIL async_reset: got bus=%h busy/rd_en=%b, want %h 00", bus, {busy, rd_en}, INIT_BUS);
    end
    cyc();
    sys_rst_n = 1'b1; rd_end = 1'b1;
    cyc();
    cyc();
    n_tests++;
    if ({bus, busy, rd_en} !== {NOP_BUS, 2'b00}) begin
      n_fail++;
      $display("FAIL stale_rd_end: got bus=%h busy/rd_en=%b, want %h 00", bus, {busy, rd_en}, NOP_BUS);
    end
    rd_end = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_then_read();
    test_no_preempt();
    test_init_drop();
    test_round_robin();
    test_reset_mid_read();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending grants, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
